// File: rtl/wb_mbox_pkg.sv
// wb_mbox_pkg
// Shared definitions for the Wishbone status mailbox: register word indices,
// CTRL/STATUS bit positions and the drain FSM state encoding.
package wb_mbox_pkg;

  // Register word indices (wbs_adr_i[4:2])
  localparam logic [2:0] IDX_CTRL   = 3'd0;
  localparam logic [2:0] IDX_STATUS = 3'd1;
  localparam logic [2:0] IDX_PUSH   = 3'd2;
  localparam logic [2:0] IDX_DIRECT = 3'd3;
  localparam logic [2:0] IDX_HOLD   = 3'd4;

  // CTRL bit positions
  localparam int CTRL_EN  = 0;
  localparam int CTRL_OE  = 1;
  localparam int CTRL_CLR = 2;

  // STATUS bit positions (level occupies [5:0])
  localparam int STAT_EMPTY = 8;
  localparam int STAT_FULL  = 9;
  localparam int STAT_OVF   = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } drain_state_t;

endpackage

// File: rtl/wb_mbox_fifo.sv
// wb_mbox_fifo
// Synchronous FIFO holding status words between firmware pushes and the
// drain FSM. Push on full and pop on empty are ignored; flush empties the
// FIFO on the next clock edge and wins over a simultaneous push/pop.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        synchronous clear of all entries
//   push, wdata  write request and data
//   pop, rdata   read request; rdata always shows the head entry
//   level        number of stored entries (0..DEPTH)
//   full, empty  status flags
module wb_mbox_fifo
  import wb_mbox_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign level   = count_reg;
  assign rdata   = mem[rd_ptr_reg];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // Storage has no reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/wb_status_mailbox.sv
// wb_status_mailbox
// Wishbone responder that queues status words from the management SoC and
// sequences them onto a 16-bit status bus with a programmable hold time per
// word, or drives a single DIRECT value when the drain engine is disabled.
// Optional build macro: WB_MBOX_ERR_EN -- unmapped accesses, STATUS writes
// and PUSH reads terminate with wbs_err_o instead of wbs_ack_o.
// Ports:
//   wb_clk_i, wb_rst_n        clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i      Wishbone cycle, strobe, write enable
//   wbs_adr_i, wbs_sel_i      byte address ([4:2] = register), byte lanes
//   wbs_dat_i, wbs_dat_o      write data, registered read data
//   wbs_ack_o, wbs_err_o      single-cycle acknowledge / error
//   status_o, status_oe_n     status word and active-low pad enables
//   irq_o                     FIFO drained and FSM idle while enabled
// HOLD_W must not exceed 32.
module wb_status_mailbox
  import wb_mbox_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int HOLD_W     = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [7:0]  wbs_adr_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic [15:0] status_o,
  output logic [15:0] status_oe_n,
  output logic        irq_o
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]        idx;
  logic              req;
  logic              bad;
  logic              wr_ok;
  logic              rd_ok;
  logic              ctrl_clr;
  logic              push_req;
  logic [31:0]       rdata;

  logic              en_reg;
  logic              oe_reg;
  logic              ovf_reg;
  logic [15:0]       direct_reg;
  logic [HOLD_W-1:0] hold_reg;
  logic [HOLD_W-1:0] hold_next;
  logic [HOLD_W-1:0] hold_load;
  logic [HOLD_W-1:0] cnt_reg;
  logic [15:0]       word_reg;

  drain_state_t      state_reg;
  drain_state_t      state_next;
  logic              pop;

  logic [15:0]       fifo_head;
  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_full;
  logic              fifo_empty;

  logic              unused_ok;
  assign unused_ok = ^{wbs_adr_i[7:5], wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

  assign idx = wbs_adr_i[4:2];
  // A new request is only taken while no response is on the bus, which is
  // what gives a held strobe one response every second cycle.
  assign req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o;

`ifdef WB_MBOX_ERR_EN
  always_comb begin
    bad = 1'b0;
    if (idx > IDX_HOLD)                       bad = 1'b1;
    if (wbs_we_i  && (idx == IDX_STATUS))     bad = 1'b1;
    if (!wbs_we_i && (idx == IDX_PUSH))       bad = 1'b1;
  end
`else
  assign bad = 1'b0;
`endif

  assign wr_ok    = req & wbs_we_i & ~bad;
  assign rd_ok    = req & ~wbs_we_i & ~bad;
  assign ctrl_clr = wr_ok & (idx == IDX_CTRL) & wbs_sel_i[0] & wbs_dat_i[CTRL_CLR];
  assign push_req = wr_ok & (idx == IDX_PUSH) & (wbs_sel_i[1:0] == 2'b11);

  // Read mux; CLR and PUSH read back as zero.
  always_comb begin
    rdata = 32'h0;
    case (idx)
      IDX_CTRL:   rdata = {30'h0, oe_reg, en_reg};
      IDX_STATUS: begin
        rdata[5:0]        = 6'(fifo_level);
        rdata[STAT_EMPTY] = fifo_empty;
        rdata[STAT_FULL]  = fifo_full;
        rdata[STAT_OVF]   = ovf_reg;
      end
      IDX_DIRECT: rdata = {16'h0, direct_reg};
      IDX_HOLD:   rdata = 32'(hold_reg);
      default:    rdata = 32'h0;
    endcase
  end

  // Byte-lane merge of a HOLD write.
  always_comb begin
    hold_next = hold_reg;
    if (wr_ok && (idx == IDX_HOLD)) begin
      for (int b = 0; b < HOLD_W; b++) begin
        if (wbs_sel_i[b / 8]) hold_next[b] = wbs_dat_i[b];
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
    end else begin
      wbs_ack_o <= req & ~bad;
      wbs_dat_o <= rd_ok ? rdata : 32'h0;
    end
  end

`ifdef WB_MBOX_ERR_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) wbs_err_o <= 1'b0;
    else           wbs_err_o <= req & bad;
  end
`else
  assign wbs_err_o = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      en_reg     <= 1'b0;
      oe_reg     <= 1'b0;
      ovf_reg    <= 1'b0;
      direct_reg <= 16'h0;
      hold_reg   <= HOLD_W'(1);
    end else begin
      hold_reg <= hold_next;
      if (wr_ok && (idx == IDX_CTRL) && wbs_sel_i[0]) begin
        en_reg <= wbs_dat_i[CTRL_EN];
        oe_reg <= wbs_dat_i[CTRL_OE];
      end
      if (wr_ok && (idx == IDX_DIRECT)) begin
        if (wbs_sel_i[0]) direct_reg[7:0]  <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) direct_reg[15:8] <= wbs_dat_i[15:8];
      end
      if (ctrl_clr)                   ovf_reg <= 1'b0;
      else if (push_req && fifo_full) ovf_reg <= 1'b1;
    end
  end

  wb_mbox_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n),
    .flush (ctrl_clr),
    .push  (push_req),
    .wdata (wbs_dat_i[15:0]),
    .pop   (pop),
    .rdata (fifo_head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Hold of 0 behaves as 1, so the counter starts at max(HOLD,1)-1.
  assign hold_load = (hold_reg == '0) ? '0 : hold_reg - 1'b1;

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: if (!fifo_empty) state_next = ST_LOAD;
      ST_LOAD: begin
        pop        = ~fifo_empty;
        state_next = ST_HOLD;
      end
      ST_HOLD: if (cnt_reg == '0) state_next = fifo_empty ? ST_IDLE : ST_LOAD;
      default: state_next = ST_IDLE;
    endcase
    // Disable or flush parks the engine; the FIFO keeps its contents on disable.
    if (!en_reg || ctrl_clr) begin
      state_next = ST_IDLE;
      pop        = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      word_reg  <= 16'h0;
    end else begin
      state_reg <= state_next;
      if (pop) word_reg <= fifo_head;
      if (state_reg == ST_LOAD)                    cnt_reg <= hold_load;
      else if (state_reg == ST_HOLD && cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign status_o    = en_reg ? word_reg : direct_reg;
  assign status_oe_n = {16{~oe_reg}};
  assign irq_o       = en_reg & fifo_empty & (state_reg == ST_IDLE);

endmodule

// File: tb/tb_wb_status_mailbox.sv
module tb_wb_status_mailbox;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [7:0]  wbs_adr_i = 8'h0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_dat_i = 32'h0;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic [15:0] status_o;
  logic [15:0] status_oe_n;
  logic        irq_o;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_status_mailbox #(
    .FIFO_DEPTH (8),
    .HOLD_W     (16)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_n    (wb_rst_n),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_dat_o   (wbs_dat_o),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_err_o   (wbs_err_o),
    .status_o    (status_o),
    .status_oe_n (status_oe_n),
    .irq_o       (irq_o)
  );

`ifdef WB_MBOX_ERR_EN
  localparam bit ERR_MODE = 1'b1;
`else
  localparam bit ERR_MODE = 1'b0;
`endif

  typedef struct { logic [31:0] data; bit is_err; bit chk; } bus_exp_t;
  typedef struct { logic [15:0] val; int len; } st_exp_t;
  typedef struct { int kind; logic [31:0] exp; } probe_t;

  bus_exp_t bus_q[$];
  string    bus_name_q[$];
  st_exp_t  st_q[$];
  probe_t   probe_q[$];
  string    probe_name_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_on = 1'b0;
  bit timed_out = 1'b0;

  bit          mon_on_d = 1'b0;
  bit          have_run = 1'b0;
  logic [15:0] mon_prev = 16'h0;
  int          run_len = 0;
  int          run_exp = 0;

  // Single checking process: bus responses, status_o stream, direct probes.
  always @(negedge wb_clk_i) begin : monitor
    bus_exp_t    be;
    st_exp_t     se;
    probe_t      p;
    string       nm;
    logic [31:0] act;

    if (wbs_ack_o || wbs_err_o) begin
      if (bus_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_resp: ack=%0b err=%0b, required no response", wbs_ack_o, wbs_err_o);
      end else begin
        be = bus_q.pop_front();
        nm = bus_name_q.pop_front();
        $display("txn %-18s ack=%0b err=%0b dat=%08h", nm, wbs_ack_o, wbs_err_o, wbs_dat_o);
        n_cmp++;
        if (wbs_err_o !== be.is_err || wbs_ack_o !== !be.is_err) begin
          n_bad++;
          $display("FAIL %s_resp: ack=%0b err=%0b, required err=%0b", nm, wbs_ack_o, wbs_err_o, be.is_err);
        end
        if (be.chk) begin
          n_cmp++;
          if (wbs_dat_o !== be.data) begin
            n_bad++;
            $display("FAIL %s_data: got %08h, required %08h", nm, wbs_dat_o, be.data);
          end
        end
      end
    end

    while (probe_q.size() > 0) begin
      p  = probe_q.pop_front();
      nm = probe_name_q.pop_front();
      case (p.kind)
        0:       act = {16'h0, status_o};
        1:       act = {16'h0, status_oe_n};
        2:       act = {31'h0, irq_o};
        3:       act = {30'h0, wbs_err_o, wbs_ack_o};
        4:       act = 32'(st_q.size());
        default: act = {31'h0, timed_out};
      endcase
      n_cmp++;
      if (act !== p.exp) begin
        n_bad++;
        $display("FAIL %s: got %0h, required %0h", nm, act, p.exp);
      end
    end

    if (mon_on && !mon_on_d) begin
      mon_prev = status_o;
      have_run = 1'b0;
    end else if (mon_on) begin
      if (status_o !== mon_prev) begin
        if (have_run && run_exp != 0) begin
          n_cmp++;
          if (run_len != run_exp) begin
            n_bad++;
            $display("FAIL hold_len_%04h: got %0d cycles, required %0d", mon_prev, run_len, run_exp);
          end
        end
        n_cmp++;
        if (st_q.size() == 0) begin
          n_bad++;
          $display("FAIL status_word: got %04h, required no change", status_o);
        end else begin
          se = st_q.pop_front();
          if (status_o !== se.val) begin
            n_bad++;
            $display("FAIL status_word: got %04h, required %04h", status_o, se.val);
          end
          run_exp = se.len;
        end
        $display("txn status_o -> %04h", status_o);
        have_run = 1'b1;
        run_len  = 1;
        mon_prev = status_o;
      end else begin
        run_len++;
      end
    end
    mon_on_d = mon_on;
  end

  task automatic probe(input string nm, input int kind, input logic [31:0] exp);
    probe_t p;
    p.kind = kind;
    p.exp  = exp;
    probe_q.push_back(p);
    probe_name_q.push_back(nm);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  // Let the monitor evaluate pending probes, then return to posedge+1.
  task automatic settle();
    @(negedge wb_clk_i);
    cycles(1);
  endtask

  task automatic flag_timeout(input string nm);
    timed_out = 1'b1;
    probe(nm, 5, 32'h0);
    settle();
    timed_out = 1'b0;
  endtask

  task automatic wb_xfer(input string nm, input bit w, input logic [2:0] idx,
                         input logic [3:0] s, input logic [31:0] d,
                         input bit chk, input logic [31:0] exp, input bit exp_err);
    bus_exp_t e;
    int n;
    e.data = exp; e.is_err = exp_err; e.chk = chk;
    bus_q.push_back(e);
    bus_name_q.push_back(nm);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = w;
    wbs_adr_i = {3'b000, idx, 2'b01};
    wbs_sel_i = s; wbs_dat_i = d;
    n = 0;
    do begin
      @(posedge wb_clk_i); #1; n++;
    end while (!(wbs_ack_o || wbs_err_o) && n < 20);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    if (n >= 20) begin
      void'(bus_q.pop_back());
      void'(bus_name_q.pop_back());
      flag_timeout({nm, "_timeout"});
    end
  endtask

  task automatic wr(input string nm, input logic [2:0] idx, input logic [3:0] s, input logic [31:0] d);
    wb_xfer(nm, 1'b1, idx, s, d, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic rd(input string nm, input logic [2:0] idx, input logic [31:0] exp);
    wb_xfer(nm, 1'b0, idx, 4'hF, 32'h0, 1'b1, exp, 1'b0);
  endtask

  task automatic wait_irq(input string nm);
    int n;
    n = 0;
    while (!irq_o && n < 100) begin
      cycles(1);
      n++;
    end
    if (n >= 100) flag_timeout(nm);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    cycles(3);
    probe("rst_status_o", 0, 32'h0);
    probe("rst_oe_n", 1, 32'hFFFF);
    probe("rst_irq", 2, 32'h0);
    probe("rst_ack_err", 3, 32'h0);
    settle();
    wb_rst_n = 1'b1;
    cycles(1);

    rd("rd_status_reset", 3'd1, 32'h0000_0100);
    rd("rd_hold_reset", 3'd4, 32'h0000_0001);

    // Direct-drive mode
    wr("wr_ctrl_oe", 3'd0, 4'hF, 32'h2);
    wr("wr_direct", 3'd3, 4'hF, 32'h0000_AB60);
    probe("direct_out", 0, 32'hAB60);
    probe("oe_on", 1, 32'h0);
    settle();
    rd("rd_direct", 3'd3, 32'h0000_AB60);
    rd("rd_ctrl", 3'd0, 32'h2);

    // Drain with HOLD=4: each word visible 5 cycles
    wr("wr_hold4", 3'd4, 4'hF, 32'h4);
    rd("rd_hold4", 3'd4, 32'h4);
    wr("wr_ctrl_en", 3'd0, 4'hF, 32'h3);
    st_q.push_back('{16'hAB60, 5});
    st_q.push_back('{16'hAB61, 5});
    st_q.push_back('{16'hAB62, 0});
    mon_on = 1'b1;
    probe("irq_idle_en", 2, 32'h1);
    settle();
    wr("push_ab60", 3'd2, 4'hF, 32'h0000_AB60);
    wr("push_ab61", 3'd2, 4'hF, 32'h0000_AB61);
    wr("push_ab62", 3'd2, 4'hF, 32'h0000_AB62);
    probe("irq_busy", 2, 32'h0);
    settle();
    wait_irq("irq_drain1_timeout");
    probe("irq_drained", 2, 32'h1);
    probe("last_word", 0, 32'hAB62);
    probe("stream1_done", 4, 32'h0);
    settle();
    mon_on = 1'b0;
    rd("rd_status_drained", 3'd1, 32'h0000_0100);

    // Overflow with the engine disabled
    wr("wr_ctrl_dis", 3'd0, 4'hF, 32'h2);
    for (int i = 0; i < 9; i++) wr($sformatf("push_ovf%0d", i), 3'd2, 4'h3, 32'h0100 + i);
    rd("rd_status_full", 3'd1, 32'h0000_0608);
    probe("irq_disabled", 2, 32'h0);
    settle();
    wr("wr_ctrl_clr", 3'd0, 4'h1, 32'h6);
    rd("rd_status_clr", 3'd1, 32'h0000_0100);
    rd("rd_ctrl_clr0", 3'd0, 32'h2);

    // Partial-lane pushes and byte writes
    wr("push_sel1", 3'd2, 4'h1, 32'h0000_1234);
    rd("rd_status_sel1", 3'd1, 32'h0000_0100);
    wr("push_sel3", 3'd2, 4'h3, 32'h0000_1234);
    rd("rd_status_sel3", 3'd1, 32'h0000_0001);
    wr("wr_direct_b1", 3'd3, 4'h2, 32'h0000_5500);
    rd("rd_direct_b1", 3'd3, 32'h0000_5560);
    probe("direct_b1_out", 0, 32'h5560);
    settle();

    // Illegal / unmapped accesses
    wb_xfer("rd_idx6", 1'b0, 3'd6, 4'hF, 32'h0, !ERR_MODE, 32'h0, ERR_MODE);
    wb_xfer("wr_status", 1'b1, 3'd1, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0, ERR_MODE);
    rd("rd_status_kept", 3'd1, 32'h0000_0001);
    wb_xfer("rd_push", 1'b0, 3'd2, 4'hF, 32'h0, !ERR_MODE, 32'h0, ERR_MODE);
    wb_xfer("wr_idx7", 1'b1, 3'd7, 4'hF, 32'h3, 1'b0, 32'h0, ERR_MODE);
    rd("rd_ctrl_kept", 3'd0, 32'h2);

    // HOLD=0 behaves as 1: each word visible 2 cycles
    wr("wr_ctrl_clr2", 3'd0, 4'h1, 32'h6);
    wr("wr_hold0", 3'd4, 4'h3, 32'h0);
    rd("rd_hold0", 3'd4, 32'h0);
    wr("wr_ctrl_en2", 3'd0, 4'hF, 32'h3);
    st_q.push_back('{16'h1111, 2});
    st_q.push_back('{16'h2222, 0});
    mon_on = 1'b1;
    settle();
    wr("push_1111", 3'd2, 4'h3, 32'h0000_1111);
    wr("push_2222", 3'd2, 4'h3, 32'h0000_2222);
    wait_irq("irq_drain2_timeout");
    probe("last_word2", 0, 32'h2222);
    probe("stream2_done", 4, 32'h0);
    settle();
    mon_on = 1'b0;
    cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
